burst_mem_responder: RTL and testbench

- Responder (memory side) of the 64-bit, 4-beat burst interface driven by cacheline_adaptor.
- Accepts one 256-bit cache-line read or write per transaction.
- Inserts a programmable access latency, then moves four 64-bit beats, each qualified by mem_resp.
- Used as the physical-memory model/controller under memory_hierarchy in simulation and on FPGA; backed by an internal line array.

---
 rtl/mem_burst_pkg.sv | 17 +
 rtl/burst_line_ram.sv | 34 +++
 rtl/burst_mem_responder.sv | 133 +++++++++++++
 tb/tb_burst_mem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the burst memory responder.
// One line = four 64-bit beats, addressed on 32-byte boundaries.
package mem_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } state_e;

  localparam int BEATS       = 4;
  localparam int BEAT_W      = 64;
  localparam int LINE_W      = 256;
  localparam int LINE_OFFSET = 5;

endpackage

// File: rtl/burst_line_ram.sv
// Line store split into four beat-wide banks.
// Async read of the selected beat, sync write into one bank.
module burst_line_ram
  import mem_burst_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_idx,
  input  logic [1:0]           i_beat,
  input  logic [BEAT_W-1:0]    i_wdata,
  output logic [BEAT_W-1:0]    o_rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [BEAT_W-1:0] w_rd [BEATS];

  for (genvar b = 0; b < BEATS; b++) begin : g_bank
    logic [BEAT_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (i_we && i_beat == 2'(b)) begin
        r_mem[i_idx] <= i_wdata;
      end
    end

    assign w_rd[b] = r_mem[i_idx];
  end

  assign o_rdata = w_rd[i_beat];

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat 64-bit line burst protocol.
// Accepts a request, waits LATENCY cycles, then strobes four beats.
module burst_mem_responder
  import mem_burst_pkg::*;
#(
  parameter int LATENCY   = 10,
  parameter int ADDR_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [BEAT_W-1:0] mem_wdata,
  output logic              mem_resp,
  output logic [BEAT_W-1:0] mem_rdata,
  output logic              err,
  output logic              busy
);

  localparam int LAT_W =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD =
    (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;
  localparam int IDX_HI = ADDR_BITS + LINE_OFFSET - 1;

  state_e               r_state;
  logic                 r_op_wr;
  logic [ADDR_BITS-1:0] r_idx;
  logic [LAT_W-1:0]     r_lat;
  logic [1:0]           r_beat;
  logic                 r_resp;
  logic                 r_err;

  state_e               w_nx;
  logic                 w_req_ok;
  logic                 w_accept;
  logic                 w_both;
  logic                 w_abort;
  logic                 w_we;
  logic [BEAT_W-1:0]    w_ram_rd;
  logic                 w_unused;

  // Offset and high address bits alias onto the same line.
  assign w_unused = ^{mem_address[31:IDX_HI+1],
                      mem_address[LINE_OFFSET-1:0]};

  // Captured request must stay held, with the other one low.
  assign w_req_ok = r_op_wr ? (mem_write && !mem_read)
                            : (mem_read && !mem_write);

  always_comb begin
    w_nx     = r_state;
    w_accept = 1'b0;
    w_both   = 1'b0;
    w_abort  = 1'b0;
    w_we     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (mem_read ^ mem_write) begin
          w_accept = 1'b1;
          w_nx = (LATENCY > 0) ? WAIT : BURST;
        end else if (mem_read && mem_write) begin
          w_both = 1'b1;
        end
      end
      WAIT: begin
        if (!w_req_ok) begin
          w_abort = 1'b1;
          w_nx = IDLE;
        end else if (r_lat == '0) begin
          w_nx = BURST;
        end
      end
      BURST: begin
        if (!w_req_ok) begin
          w_abort = 1'b1;
          w_nx = IDLE;
        end else begin
          w_we = r_op_wr;
          if (r_beat == 2'd3) w_nx = DONE;
        end
      end
      DONE: w_nx = IDLE;
      default: w_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op_wr <= 1'b0;
      r_idx   <= '0;
      r_lat   <= '0;
      r_beat  <= '0;
      r_resp  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nx;
      r_resp  <= (w_nx == BURST);
      r_err   <= r_err | w_both | w_abort;
      if (w_accept) begin
        r_op_wr <= mem_write;
        r_idx   <= mem_address[IDX_HI:LINE_OFFSET];
        r_lat   <= LAT_LOAD;
        r_beat  <= '0;
      end else if (w_abort) begin
        r_beat  <= '0;
      end else if (r_state == WAIT) begin
        if (r_lat != '0) r_lat <= r_lat - 1'b1;
      end else if (r_state == BURST) begin
        r_beat  <= r_beat + 2'd1;
      end
    end
  end

  burst_line_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_idx  (r_idx),
    .i_beat (r_beat),
    .i_wdata(mem_wdata),
    .o_rdata(w_ram_rd)
  );

  assign mem_resp  = r_resp;
  assign mem_rdata = (r_resp && !r_op_wr) ? w_ram_rd : '0;
  assign err       = r_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: LATENCY=10 and LATENCY=0 instances
// against a transaction-level model of the burst protocol.
module tb_burst_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [63:0] wdata [2];
  logic        resp  [2];
  logic [63:0] rdata [2];
  logic        err   [2];
  logic        busy  [2];

  logic        e_resp  [2];
  logic [63:0] e_rdata [2];
  logic        e_err   [2];
  logic        e_busy  [2];
  logic        p_resp  [2];

  logic [63:0] mdl [2][256][4];
  logic [63:0] got [$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc    = 0;
  int rise   [2];
  bit en     = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  burst_mem_responder #(.LATENCY(10), .ADDR_BITS(8)) d0 (
    .clk(clk), .rst(rst),
    .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_address(addr[0]), .mem_wdata(wdata[0]),
    .mem_resp(resp[0]), .mem_rdata(rdata[0]),
    .err(err[0]), .busy(busy[0])
  );

  burst_mem_responder #(.LATENCY(0), .ADDR_BITS(8)) d1 (
    .clk(clk), .rst(rst),
    .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_address(addr[1]), .mem_wdata(wdata[1]),
    .mem_resp(resp[1]), .mem_rdata(rdata[1]),
    .err(err[1]), .busy(busy[1])
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("resp%0d", k), 64'(resp[k]), 64'(e_resp[k]));
        chk($sformatf("rdata%0d", k), rdata[k], e_rdata[k]);
        chk($sformatf("err%0d", k), 64'(err[k]), 64'(e_err[k]));
        chk($sformatf("busy%0d", k), 64'(busy[k]), 64'(e_busy[k]));
        if (resp[k] && !p_resp[k]) rise[k] = cyc + 1;
        if (resp[k] && rd[k]) got.push_back(rdata[k]);
        p_resp[k] = resp[k];
      end
    end
  end

  task automatic clear_exp();
    for (int k = 0; k < 2; k++) begin
      e_resp[k] = 0; e_rdata[k] = 0;
      e_err[k] = 0; e_busy[k] = 0;
    end
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      rd[k] = 0; wr[k] = 0;
      addr[k] = 0; wdata[k] = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; idle_inputs();
    @(posedge clk); #1;
    rst = 0; clear_exp();
  endtask

  // One line transaction; drop = beat index at which the
  // initiator releases its request early (-1 = full burst).
  task automatic txn(int k, bit w, logic [31:0] a,
                     logic [255:0] d, int drop);
    int L;
    logic [7:0] idx;
    L = (k == 0) ? 10 : 0;
    idx = a[12:5];
    @(posedge clk); #1;
    rd[k] = !w; wr[k] = w; addr[k] = a;
    @(posedge clk); #1;
    acc = cyc;
    addr[k] = $urandom;
    e_busy[k] = 1;
    repeat (L) begin
      e_resp[k] = 0; e_rdata[k] = 0;
      wdata[k] = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    for (int b = 0; b < 4; b++) begin
      e_resp[k] = 1;
      e_rdata[k] = w ? 64'd0 : mdl[k][idx][b];
      if (b == drop) begin
        if (w) wr[k] = 0; else rd[k] = 0;
        @(posedge clk); #1;
        e_resp[k] = 0; e_rdata[k] = 0;
        e_busy[k] = 0; e_err[k] = 1;
        return;
      end
      wdata[k] = d[64*b +: 64];
      @(posedge clk); #1;
      if (w) mdl[k][idx][b] = d[64*b +: 64];
    end
    e_resp[k] = 0; e_rdata[k] = 0;
    rd[k] = 0; wr[k] = 0;
    @(posedge clk); #1;
    e_busy[k] = 0;
  endtask

  task automatic chk_got(string nm, logic [255:0] exp);
    chk({nm, "_n"}, 64'(got.size()), 64'd4);
    for (int b = 0; b < 4; b++) begin
      if (b < got.size())
        chk($sformatf("%s_b%0d", nm, b), got[b], exp[64*b +: 64]);
    end
    got.delete();
  endtask

  localparam logic [255:0] L1 = {
    64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] L2 = {
    64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] L2MIX = {
    64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] L3 = {
    64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
    64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    clear_exp();
    for (int k = 0; k < 2; k++) begin
      p_resp[k] = 0; rise[k] = 0;
    end
    do_reset();
    en = 1;
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_resp", 64'(resp[0]), 64'd0);

    txn(0, 1, 32'h0000_0040, L1, -1);
    chk("wr_lat10", 64'(rise[0] - acc), 64'd11);
    got.delete();
    txn(0, 0, 32'h0000_0040, 0, -1);
    chk_got("rd_after_wr", L1);

    @(posedge clk); #1;
    rd[0] = 1; wr[0] = 1;
    @(posedge clk); #1;
    e_err[0] = 1;
    repeat (4) @(posedge clk);
    #1;
    rd[0] = 0; wr[0] = 0;
    @(posedge clk); #1;
    chk("both_err", 64'(err[0]), 64'd1);
    do_reset();

    txn(0, 1, 32'h0000_0040, L2, 2);
    @(posedge clk); #1;
    chk("drop_err", 64'(err[0]), 64'd1);
    got.delete();
    txn(0, 0, 32'h0000_0040, 0, -1);
    chk_got("partial", L2MIX);
    do_reset();

    @(posedge clk); #1;
    rd[0] = 1; addr[0] = 32'h0000_0040;
    @(posedge clk); #1;
    e_busy[0] = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1; rd[0] = 0;
    @(posedge clk); #1;
    rst = 0; clear_exp();
    chk("wrst_resp", 64'(resp[0]), 64'd0);
    chk("wrst_busy", 64'(busy[0]), 64'd0);
    chk("wrst_err", 64'(err[0]), 64'd0);
    got.delete();
    txn(0, 0, 32'h0000_0040, 0, -1);
    chk_got("rd_after_rst", L2MIX);

    txn(1, 1, 32'h0000_0040, L3, -1);
    chk("wr_lat0", 64'(rise[1] - acc), 64'd1);
    got.delete();
    txn(1, 0, 32'h0000_2040, 0, -1);
    chk("rd_lat0", 64'(rise[1] - acc), 64'd1);
    chk_got("alias", L3);

    repeat (3) @(posedge clk);
    #1;
    en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
